// File: rtl/fft_pkg.sv
// Shared constants for the radix-2 butterfly stage: default widths, twiddle fraction
// bits and the two-state input FSM encoding.
package fft_pkg;
  localparam int TW_FRAC       = 14;
  localparam int DEF_BIT_WIDTH = 29;
  localparam int DEF_TW_WIDTH  = 16;
  localparam int DEF_N         = 16;
  localparam int DEF_SIZE      = 4;

  localparam logic [0:0] WAIT_A = 1'b0;
  localparam logic [0:0] WAIT_B = 1'b1;
endpackage

// File: rtl/fft_butterfly_stage_if.sv
// Sample/twiddle input bus and result output bus of one butterfly stage.
// master = RAM/sequencer side, slave = butterfly datapath.
interface fft_butterfly_stage_if
  import fft_pkg::*;
#(
  parameter int bit_width = DEF_BIT_WIDTH,
  parameter int TW_WIDTH  = DEF_TW_WIDTH,
  parameter int SIZE      = DEF_SIZE
);
  logic                        start;
  logic                        in_valid;
  logic signed [bit_width-1:0] in_re;
  logic signed [bit_width-1:0] in_im;
  logic [SIZE-1:0]             adr_ptr1;
  logic [SIZE-1:0]             adr_ptr2;
  logic signed [TW_WIDTH-1:0]  tw_re;
  logic signed [TW_WIDTH-1:0]  tw_im;
  logic                        out_valid;
  logic signed [bit_width-1:0] out_re;
  logic signed [bit_width-1:0] out_im;
  logic [SIZE-1:0]             out_ptr;
  logic                        done_o;

  modport master (
    output start, in_valid, in_re, in_im, adr_ptr1, adr_ptr2, tw_re, tw_im,
    input  out_valid, out_re, out_im, out_ptr, done_o
  );

  modport slave (
    input  start, in_valid, in_re, in_im, adr_ptr1, adr_ptr2, tw_re, tw_im,
    output out_valid, out_re, out_im, out_ptr, done_o
  );
endinterface

// File: rtl/fft_cmult.sv
// Registered complex multiply P = D*W (Q1.14 twiddle), floor shift, wrapped to bit_width.
// One cycle latency; loads only on in_vld and holds otherwise, no backpressure.
module fft_cmult
  import fft_pkg::*;
#(
  parameter int bit_width = DEF_BIT_WIDTH,
  parameter int TW_WIDTH  = DEF_TW_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_vld,
  input  logic signed [bit_width-1:0] d_re,
  input  logic signed [bit_width-1:0] d_im,
  input  logic signed [TW_WIDTH-1:0]  w_re,
  input  logic signed [TW_WIDTH-1:0]  w_im,
  output logic signed [bit_width-1:0] p_re,
  output logic signed [bit_width-1:0] p_im
);
  localparam int PW = bit_width + TW_WIDTH;
  localparam int AW = PW + 1;

  logic signed [PW-1:0] rr, ii, ri, ir;
  logic signed [AW-1:0] acc_re, acc_im;
  logic                 unused_bits;

  always_comb begin
    rr     = PW'(d_re) * PW'(w_re);
    ii     = PW'(d_im) * PW'(w_im);
    ri     = PW'(d_re) * PW'(w_im);
    ir     = PW'(d_im) * PW'(w_re);
    acc_re = AW'(rr) - AW'(ii);
    acc_im = AW'(ri) + AW'(ir);
  end

  // Dropping the fraction bits of a two's-complement value is a floor; dropping the top bits wraps.
  assign unused_bits = ^{acc_re[TW_FRAC-1:0], acc_re[AW-1:TW_FRAC+bit_width],
                         acc_im[TW_FRAC-1:0], acc_im[AW-1:TW_FRAC+bit_width]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_re <= '0;
      p_im <= '0;
    end else if (in_vld) begin
      p_re <= acc_re[TW_FRAC +: bit_width];
      p_im <= acc_im[TW_FRAC +: bit_width];
    end
  end
endmodule

// File: rtl/fft_butterfly_stage.sv
// Radix-2 DIF butterfly: pairs A,B -> S=(A+B)/2 then P=((A-B)/2)*W, written back to adr_ptr1/adr_ptr2.
// S appears 3 cycles after B is captured, P one cycle later; no backpressure, back-to-back pairs stream.
module fft_butterfly_stage
  import fft_pkg::*;
#(
  parameter int bit_width = DEF_BIT_WIDTH,
  parameter int TW_WIDTH  = DEF_TW_WIDTH,
  parameter int N         = DEF_N,
  parameter int SIZE      = DEF_SIZE
) (
  input logic                  clk,
  input logic                  rst_n,
  fft_butterfly_stage_if.slave io
);
  localparam logic [SIZE-1:0] LAST_PAIR = SIZE'(N / 2 - 1);

  logic [0:0]                  state;
  logic signed [bit_width-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW_WIDTH-1:0]  w_re, w_im;
  logic [SIZE-1:0]             ptr_a, ptr_b;
  logic                        pair_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_A;
      a_re     <= '0;
      a_im     <= '0;
      b_re     <= '0;
      b_im     <= '0;
      w_re     <= '0;
      w_im     <= '0;
      ptr_a    <= '0;
      ptr_b    <= '0;
      pair_vld <= 1'b0;
    end else if (io.start) begin
      state    <= WAIT_A;
      pair_vld <= 1'b0;
    end else begin
      pair_vld <= 1'b0;
      if (io.in_valid) begin
        if (state == WAIT_A) begin
          a_re  <= io.in_re;
          a_im  <= io.in_im;
          ptr_a <= io.adr_ptr1;
          state <= WAIT_B;
        end else begin
          b_re     <= io.in_re;
          b_im     <= io.in_im;
          w_re     <= io.tw_re;
          w_im     <= io.tw_im;
          ptr_b    <= io.adr_ptr2;
          state    <= WAIT_A;
          pair_vld <= 1'b1;
        end
      end
    end
  end

  // One guard bit makes A+B / A-B exact; dropping bit 0 is the floor halving.
  logic signed [bit_width:0] sum_re, sum_im, dif_re, dif_im;
  logic                      unused_lsb;

  always_comb begin
    sum_re = {a_re[bit_width-1], a_re} + {b_re[bit_width-1], b_re};
    sum_im = {a_im[bit_width-1], a_im} + {b_im[bit_width-1], b_im};
    dif_re = {a_re[bit_width-1], a_re} - {b_re[bit_width-1], b_re};
    dif_im = {a_im[bit_width-1], a_im} - {b_im[bit_width-1], b_im};
  end

  assign unused_lsb = ^{sum_re[0], sum_im[0], dif_re[0], dif_im[0]};

  logic                        s1_vld;
  logic signed [bit_width-1:0] s1_re, s1_im, d_re, d_im;
  logic signed [TW_WIDTH-1:0]  w1_re, w1_im;
  logic [SIZE-1:0]             p1_a, p1_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_re  <= '0;
      s1_im  <= '0;
      d_re   <= '0;
      d_im   <= '0;
      w1_re  <= '0;
      w1_im  <= '0;
      p1_a   <= '0;
      p1_b   <= '0;
    end else if (io.start) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= pair_vld;
      if (pair_vld) begin
        s1_re <= sum_re[bit_width:1];
        s1_im <= sum_im[bit_width:1];
        d_re  <= dif_re[bit_width:1];
        d_im  <= dif_im[bit_width:1];
        w1_re <= w_re;
        w1_im <= w_im;
        p1_a  <= ptr_a;
        p1_b  <= ptr_b;
      end
    end
  end

  logic signed [bit_width-1:0] p_re, p_im;

  fft_cmult #(
    .bit_width (bit_width),
    .TW_WIDTH  (TW_WIDTH)
  ) u_cmult (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (s1_vld),
    .d_re   (d_re),
    .d_im   (d_im),
    .w_re   (w1_re),
    .w_im   (w1_im),
    .p_re   (p_re),
    .p_im   (p_im)
  );

  logic                        s2_vld;
  logic signed [bit_width-1:0] s2_re, s2_im;
  logic [SIZE-1:0]             p2_a, p2_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_re  <= '0;
      s2_im  <= '0;
      p2_a   <= '0;
      p2_b   <= '0;
    end else if (io.start) begin
      s2_vld <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_re <= s1_re;
        s2_im <= s1_im;
        p2_a  <= p1_a;
        p2_b  <= p1_b;
      end
    end
  end

  logic                        out_valid, emit_p, last_p, done_o;
  logic signed [bit_width-1:0] out_re, out_im;
  logic [SIZE-1:0]             out_ptr, pair_cnt;

  // P and its pointer stay stable in the stage-2 registers for the extra cycle, since the
  // next pair can reload them at the earliest on the cycle P is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_ptr   <= '0;
      emit_p    <= 1'b0;
      last_p    <= 1'b0;
      done_o    <= 1'b0;
      pair_cnt  <= '0;
    end else if (io.start) begin
      out_valid <= 1'b0;
      emit_p    <= 1'b0;
      last_p    <= 1'b0;
      done_o    <= 1'b0;
      pair_cnt  <= '0;
    end else begin
      done_o    <= last_p;
      last_p    <= 1'b0;
      emit_p    <= 1'b0;
      out_valid <= s2_vld | emit_p;
      if (s2_vld) begin
        out_re  <= s2_re;
        out_im  <= s2_im;
        out_ptr <= p2_a;
        emit_p  <= 1'b1;
      end else if (emit_p) begin
        out_re   <= p_re;
        out_im   <= p_im;
        out_ptr  <= p2_b;
        last_p   <= (pair_cnt == LAST_PAIR);
        pair_cnt <= (pair_cnt == LAST_PAIR) ? '0 : pair_cnt + SIZE'(1);
      end
    end
  end

  assign io.out_valid = out_valid;
  assign io.out_re    = out_re;
  assign io.out_im    = out_im;
  assign io.out_ptr   = out_ptr;
  assign io.done_o    = done_o;
endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Directed bench for fft_butterfly_stage: queue-based golden model checked every cycle,
// plus literal expectations on selected beats.
`timescale 1ns/1ps
module tb_fft_butterfly_stage;
  import fft_pkg::*;

  localparam int BW = 29;
  localparam int TW = 16;
  localparam int NP = 16;
  localparam int SZ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_butterfly_stage_if #(.bit_width(BW), .TW_WIDTH(TW), .SIZE(SZ)) bus ();

  fft_butterfly_stage #(.bit_width(BW), .TW_WIDTH(TW), .N(NP), .SIZE(SZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  typedef struct {
    longint re;
    longint im;
    int     ptr;
    int     cyc;
    bit     is_p;
  } beat_t;

  beat_t  expq[$];
  beat_t  logq[$];
  beat_t  e_cur;
  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  int     pcount = 0;
  int     done_due = -1;
  int     done_seen = 0;
  int     done_cyc = -1;
  int     last_b_cyc = 0;
  longint pa_re, pa_im;
  int     pa_ptr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint wrap(longint v);
    return (v <<< (64 - BW)) >>> (64 - BW);
  endfunction

  // Golden butterfly: plain integer arithmetic on the pair, then the two expected beats.
  task automatic model_pair(longint ar, longint ai, int p1, longint br, longint bi, int p2,
                            longint wr, longint wi, int k);
    longint sr, si, dr, di, pr, pi;
    sr = (ar + br) >>> 1;
    si = (ai + bi) >>> 1;
    dr = (ar - br) >>> 1;
    di = (ai - bi) >>> 1;
    pr = wrap((dr * wr - di * wi) >>> TW_FRAC);
    pi = wrap((dr * wi + di * wr) >>> TW_FRAC);
    expq.push_back('{sr, si, p1, k + 3, 1'b0});
    expq.push_back('{pr, pi, p2, k + 4, 1'b1});
  endtask

  task automatic flush_model();
    expq.delete();
    pcount   = 0;
    done_due = -1;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(longint re, longint im, int p1);
    bus.in_valid = 1'b1;
    bus.in_re    = BW'(re);
    bus.in_im    = BW'(im);
    bus.adr_ptr1 = SZ'(p1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    pa_re  = re;
    pa_im  = im;
    pa_ptr = p1;
  endtask

  task automatic send_b(longint re, longint im, int p2, longint wr, longint wi);
    bus.in_valid = 1'b1;
    bus.in_re    = BW'(re);
    bus.in_im    = BW'(im);
    bus.adr_ptr2 = SZ'(p2);
    bus.tw_re    = TW'(wr);
    bus.tw_im    = TW'(wi);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    last_b_cyc   = cyc;
    model_pair(pa_re, pa_im, pa_ptr, re, im, p2, wr, wi, cyc);
  endtask

  task automatic do_start(bit with_beat);
    bus.start    = 1'b1;
    bus.in_valid = with_beat;
    bus.in_re    = BW'(999);
    bus.in_im    = BW'(-999);
    @(posedge clk);
    flush_model();
    #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic lit(string name, int idx, longint re, longint im, int ptr);
    if (logq.size() <= idx) begin
      tests++;
      fails++;
      $display("FAIL %s: beat %0d missing, only %0d beats logged", name, idx, logq.size());
    end else begin
      check({name, "_re"}, logq[idx].re, re);
      check({name, "_im"}, logq[idx].im, im);
      check({name, "_ptr"}, longint'(logq[idx].ptr), longint'(ptr));
    end
  endtask

  // Per-cycle compare against the model queue, including beat timing and done_o.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done_o || cyc == done_due)
        check("done_o", longint'(bus.done_o), longint'(cyc == done_due));
      if (bus.done_o) begin
        done_seen++;
        done_cyc = cyc;
      end
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got (%0d,%0d) ptr %0d, expected no beat (cycle %0d)",
                   bus.out_re, bus.out_im, bus.out_ptr, cyc);
        end else begin
          e_cur = expq.pop_front();
          check("beat_re", longint'(bus.out_re), e_cur.re);
          check("beat_im", longint'(bus.out_im), e_cur.im);
          check("beat_ptr", longint'(bus.out_ptr), longint'(e_cur.ptr));
          check("beat_cycle", longint'(cyc), longint'(e_cur.cyc));
          logq.push_back('{longint'(bus.out_re), longint'(bus.out_im), int'(bus.out_ptr),
                           cyc, e_cur.is_p});
          if (e_cur.is_p) begin
            pcount++;
            if (pcount == NP / 2) begin
              pcount   = 0;
              done_due = cyc + 1;
            end
          end
        end
      end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        e_cur = expq.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_beat: got no beat, expected (%0d,%0d) ptr %0d at cycle %0d",
                 e_cur.re, e_cur.im, e_cur.ptr, e_cur.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int base, ds;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_re    = '0;
    bus.in_im    = '0;
    bus.adr_ptr1 = '0;
    bus.adr_ptr2 = '0;
    bus.tw_re    = '0;
    bus.tw_im    = '0;
    pa_re = 0; pa_im = 0; pa_ptr = 0;

    idle(2);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_re", longint'(bus.out_re), 0);
    check("rst_out_im", longint'(bus.out_im), 0);
    check("rst_out_ptr", longint'(bus.out_ptr), 0);
    check("rst_done_o", longint'(bus.done_o), 0);
    rst_n = 1'b1;
    idle(2);

    // Real-valued pair with W=1.0, then W=-j, then floor behaviour on negatives.
    base = logq.size();
    send_a(100, 0, 3);
    send_b(50, 0, 9, 16384, 0);
    idle(6);
    lit("w1_s", base, 75, 0, 3);
    lit("w1_p", base + 1, 25, 0, 9);
    if (logq.size() > base)
      check("s_latency", longint'(logq[base].cyc - last_b_cyc), 3);

    base = logq.size();
    send_a(100, 0, 5);
    send_b(50, 0, 13, 0, -16384);
    idle(6);
    lit("wmj_s", base, 75, 0, 5);
    lit("wmj_p", base + 1, 0, -25, 13);

    base = logq.size();
    send_a(-3, 5, 1);
    send_b(0, 0, 2, 0, 16384);
    idle(6);
    lit("floor_s", base, -2, 2, 1);
    lit("floor_p", base + 1, -2, -2, 2);

    base = logq.size();
    send_a(268435455, -268435456, 7);
    send_b(268435455, -268435456, 8, 16384, 0);
    idle(6);
    lit("ext_s", base, 268435455, -268435456, 7);
    lit("ext_p", base + 1, 0, 0, 8);

    // Full frame of 8 back-to-back pairs: 16 contiguous beats, one done pulse.
    do_start(1'b0);
    base = logq.size();
    ds   = done_seen;
    for (int i = 0; i < 8; i++) begin
      send_a(1000 * i + 17, -300 * i, i);
      send_b(-500 * i, 40 * i + 3, i + 8, 11585 - 2000 * i, -11585 + 1500 * i);
    end
    idle(8);
    check("frame_beats", longint'(logq.size() - base), 16);
    check("frame_done_pulses", longint'(done_seen - ds), 1);
    if (logq.size() >= base + 16) begin
      check("frame_contiguous", longint'(logq[base + 15].cyc - logq[base].cyc), 15);
      check("frame_done_cycle", longint'(done_cyc), longint'(logq[base + 15].cyc + 1));
    end

    // Reset mid-pipeline with a pending A; afterwards the first beat is an A again.
    send_a(500, 0, 4);
    send_b(100, 0, 6, 16384, 0);
    send_a(77, 1, 1);
    idle(2);
    check("pre_rst_out_valid", longint'(bus.out_valid), 1);
    rst_n = 1'b0;
    flush_model();
    #1;
    check("async_rst_out_valid", longint'(bus.out_valid), 0);
    check("async_rst_out_re", longint'(bus.out_re), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    base = logq.size();
    send_a(10, 0, 2);
    send_b(2, 0, 3, 16384, 0);
    idle(6);
    check("rst_pair_beats", longint'(logq.size() - base), 2);
    lit("rst_pair_s", base, 6, 0, 2);
    lit("rst_pair_p", base + 1, 4, 0, 3);

    // Lone A stays pending silently; start then drops a pair already in flight.
    send_a(1000, 0, 5);
    idle(8);
    do_start(1'b0);
    base = logq.size();
    send_a(7, 7, 1);
    send_b(3, 3, 2, 16384, 0);
    idle(1);
    do_start(1'b0);
    idle(8);
    check("start_drop_beats", longint'(logq.size() - base), 0);

    // A beat coinciding with start must not become the next A.
    do_start(1'b1);
    base = logq.size();
    send_a(20, 4, 9);
    send_b(4, 0, 10, 16384, 0);
    idle(6);
    lit("start_beat_s", base, 12, 2, 9);
    lit("start_beat_p", base + 1, 8, 2, 10);

    // Random data with random 0..5 cycle gaps between beats.
    do_start(1'b0);
    for (int i = 0; i < 20; i++) begin
      idle($urandom_range(0, 5));
      send_a(longint'($urandom_range(0, (1 << 29) - 1)) - (1 << 28),
             longint'($urandom_range(0, (1 << 29) - 1)) - (1 << 28),
             int'($urandom_range(0, 15)));
      idle($urandom_range(0, 5));
      send_b(longint'($urandom_range(0, (1 << 29) - 1)) - (1 << 28),
             longint'($urandom_range(0, (1 << 29) - 1)) - (1 << 28),
             int'($urandom_range(0, 15)),
             longint'($urandom_range(0, 32768)) - 16384,
             longint'($urandom_range(0, 32768)) - 16384);
    end
    idle(10);
    check("drain_pending", longint'(expq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
